// File: rtl/uart_rx_check_if.sv
// Receiver-side bundle for uart_rx_check: baud strobe, serial line, frame
// configuration and the per-frame result outputs.
interface uart_rx_check_if #(
    parameter int DSIZE = 8
);
    logic             baud_tick;
    logic             rxd;
    logic [3:0]       bitWidth;
    logic             parity_en;
    logic             oddeven;
    logic [DSIZE-1:0] data_out;
    logic             data_valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    modport master (
        output baud_tick, rxd, bitWidth, parity_en, oddeven,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  baud_tick, rxd, bitWidth, parity_en, oddeven,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_check.sv
// Oversampling UART receiver with start-glitch rejection, 5..8 data bits,
// optional even/odd parity and stop-bit (framing) check.
module uart_rx_check #(
    parameter int DSIZE = 8,
    parameter int OSR   = 16
) (
    input logic          clk,
    input logic          rst,
    uart_rx_check_if.slave bus
);
    localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [TW-1:0] C_START_CTR = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] C_BIT_CTR   = TW'(OSR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1, r_sync2;
    logic             w_rxd;
    logic [TW-1:0]    r_tick;
    logic [3:0]       r_bit;
    logic [3:0]       r_width;
    logic [3:0]       w_width_eff;
    logic             r_par_en, r_odd, r_par_bit;
    logic [DSIZE-1:0] r_shift;
    logic [DSIZE-1:0] r_data_out;
    logic             r_data_valid, r_parity_err, r_frame_err;
    logic             w_centre;
    logic             w_par_bad;

    assign w_rxd = r_sync2;

    // Bit centre: half a bit into START, then one full bit period apart.
    assign w_centre = bus.baud_tick &&
                      ((r_state == S_START) ? (r_tick == C_START_CTR)
                                            : (r_tick == C_BIT_CTR));

    // Received parity bit against XOR of data bits and the odd/even sense.
    assign w_par_bad = (^r_shift) ^ r_odd ^ r_par_bit;

    // Unsupported widths fall back to a full 8-bit frame.
    always_comb begin
        w_width_eff = 4'd8;
        case (bus.bitWidth)
            4'd5, 4'd6, 4'd7: w_width_eff = bus.bitWidth;
            default:          w_width_eff = 4'd8;
        endcase
    end

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state: every transition after IDLE happens on a bit centre.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.baud_tick && !w_rxd) w_state_nxt = S_START;
            S_START:  if (w_centre) w_state_nxt = w_rxd ? S_IDLE : S_DATA;
            S_DATA:   if (w_centre && (r_bit == r_width - 4'd1))
                          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_centre) w_state_nxt = S_STOP;
            S_STOP:   if (w_centre) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: tick/bit counters, config latch, shift register, results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick       <= '0;
            r_bit        <= '0;
            r_width      <= 4'd8;
            r_par_en     <= 1'b0;
            r_odd        <= 1'b0;
            r_par_bit    <= 1'b0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (r_state == S_IDLE)
                r_tick <= '0;
            else if (bus.baud_tick)
                r_tick <= w_centre ? '0 : r_tick + TW'(1);

            case (r_state)
                S_IDLE: begin
                    r_bit <= '0;
                    if (bus.baud_tick && !w_rxd) begin
                        r_width  <= w_width_eff;
                        r_par_en <= bus.parity_en;
                        r_odd    <= bus.oddeven;
                        r_shift  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_centre) begin
                        r_shift <= r_shift | (DSIZE'(w_rxd) << r_bit);
                        r_bit   <= r_bit + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (w_centre) r_par_bit <= w_rxd;
                end
                S_STOP: begin
                    if (w_centre) begin
                        r_data_out   <= r_shift;
                        r_parity_err <= r_par_en & w_par_bad;
                        r_frame_err  <= ~w_rxd;
                        r_data_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_check.sv
// Bench for uart_rx_check: a serial-line driver issues frames and queues the
// expected result; a monitor pops and compares on every data_valid.
`timescale 1ns/1ps
module tb_uart_rx_check;
    localparam int DSIZE = 8;
    localparam int OSR   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_check_if #(.DSIZE(DSIZE)) bif();
    uart_rx_check #(.DSIZE(DSIZE), .OSR(OSR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // baud_tick: one clk high every 3 clks
    initial begin
        bif.baud_tick = 1'b0;
        forever begin
            repeat (2) @(negedge clk);
            bif.baud_tick = 1'b1;
            @(negedge clk);
            bif.baud_tick = 1'b0;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!bif.baud_tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    function automatic int eff_w(input logic [3:0] w);
        return (w >= 4'd5 && w <= 4'd8) ? int'(w) : 8;
    endfunction

    // Drive one frame; the reference result follows from the frame contents.
    task automatic send_frame(input logic [7:0] val, input logic [3:0] w,
                              input logic pen, input logic odd, input logic flip,
                              input logic stopv, input int gap, input bit expect_out,
                              input int rst_bit, input bit scramble);
        int         n;
        logic [7:0] d;
        logic       pbit;
        exp_t       e;
        n    = eff_w(w);
        d    = val & 8'((9'd1 << n) - 9'd1);
        pbit = (^d) ^ odd ^ flip;
        bif.bitWidth  = w;
        bif.parity_en = pen;
        bif.oddeven   = odd;
        if (expect_out) begin
            e.data = d;
            e.perr = pen & flip;
            e.ferr = ~stopv;
            q.push_back(e);
        end
        bif.rxd = 1'b0;
        wait_ticks(OSR);
        if (scramble) begin
            bif.bitWidth  = 4'($urandom_range(0, 15));
            bif.parity_en = ~pen;
            bif.oddeven   = ~odd;
        end
        for (int i = 0; i < n; i++) begin
            bif.rxd = d[i];
            if (i == rst_bit) begin
                wait_ticks(OSR / 2);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                wait_ticks(OSR / 2);
            end else begin
                wait_ticks(OSR);
            end
        end
        if (pen) begin
            bif.rxd = pbit;
            wait_ticks(OSR);
        end
        bif.rxd = stopv;
        wait_ticks(OSR);
        bif.rxd = 1'b1;
        if (gap > 0) wait_ticks(gap);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
        q.delete();
    endtask

    // Monitor: compares every delivered frame and checks output hold.
    initial begin : monitor
        exp_t       e;
        logic [7:0] hold;
        logic       prev_v;
        hold   = 8'h00;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold   = 8'h00;
                prev_v = 1'b0;
            end else begin
                if (bif.data_valid) begin
                    chk("valid_one_clk", prev_v, 0);
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_valid actual=data_valid required=none data=%0h",
                                 bif.data_out);
                    end else begin
                        e = q.pop_front();
                        chk("data_out", bif.data_out, e.data);
                        chk("parity_err", bif.parity_err, e.perr);
                        chk("frame_err", bif.frame_err, e.ferr);
                        hold = e.data;
                    end
                end else begin
                    chk("data_hold", bif.data_out, hold);
                end
                prev_v = bif.data_valid;
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] w;
        logic       pen, odd, flip, stopv;
        int         gap;
        bif.rxd       = 1'b1;
        bif.bitWidth  = 4'd8;
        bif.parity_en = 1'b0;
        bif.oddeven   = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_data_out", bif.data_out, 0);
        chk("rst_data_valid", bif.data_valid, 0);
        chk("rst_parity_err", bif.parity_err, 0);
        chk("rst_frame_err", bif.frame_err, 0);
        chk("rst_busy", bif.busy, 0);
        rst = 1'b0;
        wait_ticks(OSR);

        // 8E1 0xA5, correct parity
        send_frame(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, OSR, 1'b1, -1, 1'b0);
        wait_drain("drain_a5");
        // 7O1 0x41 with a wrong parity bit
        send_frame(8'h41, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, OSR, 1'b1, -1, 1'b0);
        wait_drain("drain_41");
        // 5N1 0x1F with stop bit low
        send_frame(8'h1F, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, OSR, 1'b1, -1, 1'b0);
        wait_drain("drain_1f");
        chk("busy_after_ferr", bif.busy, 0);

        // 4-tick low glitch from idle
        bif.rxd = 1'b0;
        wait_ticks(4);
        chk("busy_in_glitch", bif.busy, 1);
        bif.rxd = 1'b1;
        wait_ticks(20);
        chk("busy_after_glitch", bif.busy, 0);
        wait_drain("drain_glitch");

        // reset during data bit 3, then a clean 0x3C
        send_frame(8'hFA, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, OSR, 1'b0, 3, 1'b0);
        chk("busy_after_abort", bif.busy, 0);
        wait_drain("drain_abort");
        send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, OSR, 1'b1, -1, 1'b0);
        wait_drain("drain_3c");

        // back-to-back 8N1 with config scrambled mid-frame
        send_frame(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, -1, 1'b1);
        send_frame(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, OSR, 1'b1, -1, 1'b1);
        wait_drain("drain_b2b");

        // random frames
        for (int k = 0; k < 36; k++) begin
            w     = 4'($urandom_range(0, 15));
            pen   = 1'($urandom_range(0, 1));
            odd   = 1'($urandom_range(0, 1));
            flip  = ($urandom_range(0, 3) == 0);
            stopv = ($urandom_range(0, 5) != 0);
            gap   = stopv ? int'($urandom_range(0, 8)) : OSR + int'($urandom_range(0, 4));
            send_frame(8'($urandom), w, pen, odd, flip, stopv, gap, 1'b1, -1,
                       ($urandom_range(0, 1) == 1));
        end
        wait_ticks(OSR);
        wait_drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
